// File: rtl/io_input_reader.sv
// Input reader: synchronises keys, switches and GPIO, debounces the keys,
// latches key-press events and serves them through a small read port.
module io_input_reader #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SW_W            = 10
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [1:0]      KEY,
    input  logic [SW_W-1:0] SW,
    input  logic [31:0]     GPIO,
    input  logic            RD,
    input  logic [1:0]      ADDR,
    output logic [31:0]     RDATA,
    output logic            RVALID,
    output logic            IRQ
);

    // Counter value on which one more differing cycle completes the debounce
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      r_key_s1;
    logic [1:0]      r_key_s2;
    logic [SW_W-1:0] r_sw_s1;
    logic [SW_W-1:0] r_sw_s2;
    logic [31:0]     r_gpio_s1;
    logic [31:0]     r_gpio_s2;

    logic [1:0]      r_deb;
    logic [7:0]      r_cnt [2];
    logic [1:0]      r_flags;
    logic [31:0]     r_rdata;
    logic            r_rvalid;
    logic            r_irq;

    logic [1:0]      w_deb_nxt;
    logic [7:0]      w_cnt_nxt [2];
    logic [1:0]      w_key_rise;
    logic            w_rd_flags;
    logic [1:0]      w_flags_nxt;
    logic [31:0]     w_sw_ext;
    logic [31:0]     w_rd_sel;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_key_s1  <= '0;
            r_key_s2  <= '0;
            r_sw_s1   <= '0;
            r_sw_s2   <= '0;
            r_gpio_s1 <= '0;
            r_gpio_s2 <= '0;
        end else begin
            r_key_s1  <= KEY;
            r_key_s2  <= r_key_s1;
            r_sw_s1   <= SW;
            r_sw_s2   <= r_sw_s1;
            r_gpio_s1 <= GPIO;
            r_gpio_s2 <= r_gpio_s1;
        end
    end

    always_comb begin
        w_deb_nxt = r_deb;
        for (int i = 0; i < 2; i++) begin
            w_cnt_nxt[i] = 8'd0;
            if (r_key_s2[i] != r_deb[i]) begin
                if (r_cnt[i] == DB_LAST) begin
                    w_deb_nxt[i] = ~r_deb[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_deb <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= 8'd0;
            end
        end else begin
            r_deb <= w_deb_nxt;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // A press landing on the same edge as a clearing read survives the clear
    always_comb begin
        w_key_rise  = w_deb_nxt & ~r_deb;
        w_rd_flags  = RD && (ADDR == 2'd2);
        w_flags_nxt = (w_rd_flags ? 2'b00 : r_flags) | w_key_rise;
    end

    always_comb begin
        w_sw_ext = '0;
        w_sw_ext[SW_W-1:0] = r_sw_s2;
        case (ADDR)
            2'd0:    w_rd_sel = w_sw_ext;
            2'd1:    w_rd_sel = r_gpio_s2;
            2'd2:    w_rd_sel = {30'b0, r_flags};
            default: w_rd_sel = {30'b0, r_deb};
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_flags  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_flags  <= w_flags_nxt;
            r_rvalid <= RD;
            r_irq    <= |w_flags_nxt;
            if (RD) begin
                r_rdata <= w_rd_sel;
            end
        end
    end

    assign RDATA  = r_rdata;
    assign RVALID = r_rvalid;
    assign IRQ    = r_irq;

endmodule

// File: tb/tb_io_input_reader.sv
// Randomised and directed bench for io_input_reader against a behavioural model.
module tb_io_input_reader;

    localparam int DB   = 4;
    localparam int SW_W = 10;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [1:0]      KEY = 2'b00;
    logic [SW_W-1:0] SW = '0;
    logic [31:0]     GPIO = '0;
    logic            RD = 1'b0;
    logic [1:0]      ADDR = 2'b00;
    logic [31:0]     RDATA;
    logic            RVALID;
    logic            IRQ;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: raw value seen one edge back, synchronized view, key model
    logic [1:0]      m_key_prev, m_key_sync;
    logic [SW_W-1:0] m_sw_prev, m_sw_sync;
    logic [31:0]     m_gpio_prev, m_gpio_sync;
    logic [1:0]      m_deb;
    int              m_streak [2];
    logic [1:0]      m_flags;
    logic [31:0]     m_rdata;
    logic            m_rvalid;
    logic            m_irq;

    io_input_reader #(
        .DEBOUNCE_CYCLES(DB),
        .SW_W           (SW_W)
    ) u_dut (
        .CLK   (CLK),
        .RST   (RST),
        .KEY   (KEY),
        .SW    (SW),
        .GPIO  (GPIO),
        .RD    (RD),
        .ADDR  (ADDR),
        .RDATA (RDATA),
        .RVALID(RVALID),
        .IRQ   (IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_key_prev  = '0;
        m_key_sync  = '0;
        m_sw_prev   = '0;
        m_sw_sync   = '0;
        m_gpio_prev = '0;
        m_gpio_sync = '0;
        m_deb       = '0;
        m_streak[0] = 0;
        m_streak[1] = 0;
        m_flags     = '0;
        m_rdata     = '0;
        m_rvalid    = 1'b0;
        m_irq       = 1'b0;
    endtask

    // Called right after a rising edge, while inputs still hold pre-edge values
    task automatic model_step();
        logic [1:0] pre_deb;
        logic [1:0] pre_flags;
        logic [1:0] pre_sync;
        logic [1:0] rise;
        pre_deb   = m_deb;
        pre_flags = m_flags;
        pre_sync  = m_key_sync;

        m_rvalid = RD;
        if (RD) begin
            case (ADDR)
                2'd0:    m_rdata = 32'(m_sw_sync);
                2'd1:    m_rdata = m_gpio_sync;
                2'd2:    m_rdata = {30'b0, pre_flags};
                default: m_rdata = {30'b0, pre_deb};
            endcase
        end

        // Key flips once DB consecutive synchronized samples disagree with it
        for (int i = 0; i < 2; i++) begin
            if (pre_sync[i] != pre_deb[i]) m_streak[i] = m_streak[i] + 1;
            else m_streak[i] = 0;
            if (m_streak[i] >= DB) begin
                m_deb[i]    = ~pre_deb[i];
                m_streak[i] = 0;
            end
        end
        rise    = m_deb & ~pre_deb;
        m_flags = ((RD && ADDR == 2'd2) ? 2'b00 : pre_flags) | rise;
        m_irq   = |m_flags;

        m_key_sync  = m_key_prev;
        m_sw_sync   = m_sw_prev;
        m_gpio_sync = m_gpio_prev;
        m_key_prev  = KEY;
        m_sw_prev   = SW;
        m_gpio_prev = GPIO;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check_val("rvalid", {31'b0, RVALID}, {31'b0, m_rvalid});
        check_val("irq", {31'b0, IRQ}, {31'b0, m_irq});
        check_val("rdata", RDATA, m_rdata);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic read(input logic [1:0] a);
        RD   = 1'b1;
        ADDR = a;
        tick();
        RD   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rdata"}, RDATA, 32'h0);
        check_val({tag, "_rvalid"}, {31'b0, RVALID}, 32'h0);
        check_val({tag, "_irq"}, {31'b0, IRQ}, 32'h0);
    endtask

    initial begin
        // Reset with keys and switches asserted
        model_reset();
        KEY = 2'b11;
        SW  = 10'h3FF;
        #1;
        check_reset_outputs("rst0");
        repeat (3) @(posedge CLK);
        #3 RST = 1'b1;
        ticks(2);
        read(2'd0);
        check_val("rst_sw_read", RDATA, 32'h0000_03FF);
        KEY = 2'b00;
        ticks(12);
        read(2'd2);
        tick();

        // Glitch of three synchronized cycles is filtered
        KEY = 2'b01;
        ticks(3);
        KEY = 2'b00;
        ticks(10);
        read(2'd3);
        check_val("glitch_deb", RDATA, 32'h0);
        check_val("glitch_irq", {31'b0, IRQ}, 32'h0);

        // Held press changes exactly 2+4 edges after the key edge
        KEY = 2'b01;
        ticks(5);
        check_val("press_irq_early", {31'b0, IRQ}, 32'h0);
        tick();
        check_val("press_irq_edge", {31'b0, IRQ}, 32'h1);
        ticks(2);
        read(2'd3);
        check_val("press_deb", RDATA, 32'h1);

        // Clear-on-read
        read(2'd2);
        KEY = 2'b11;
        ticks(8);
        RD   = 1'b1;
        ADDR = 2'd2;
        tick();
        check_val("cor_first", RDATA, 32'h2);
        check_val("cor_irq", {31'b0, IRQ}, 32'h0);
        tick();
        check_val("cor_second", RDATA, 32'h0);
        RD = 1'b0;

        // Set wins over clear on the same edge
        KEY = 2'b00;
        ticks(8);
        KEY = 2'b01;
        ticks(8);
        KEY = 2'b11;
        ticks(5);
        read(2'd2);
        check_val("setclr_rdata", RDATA, 32'h1);
        check_val("setclr_irq", {31'b0, IRQ}, 32'h1);
        tick();
        read(2'd2);
        check_val("setclr_flags", RDATA, 32'h2);

        // Streaming reads
        GPIO = 32'hDEAD_BEEF;
        SW   = 10'h155;
        ticks(2);
        RD   = 1'b1;
        ADDR = 2'd1;
        tick();
        check_val("stream_gpio", RDATA, 32'hDEAD_BEEF);
        check_val("stream_v0", {31'b0, RVALID}, 32'h1);
        ADDR = 2'd0;
        tick();
        check_val("stream_sw", RDATA, 32'h0000_0155);
        check_val("stream_v1", {31'b0, RVALID}, 32'h1);
        ADDR = 2'd3;
        tick();
        check_val("stream_keys", RDATA, 32'h3);
        check_val("stream_v2", {31'b0, RVALID}, 32'h1);
        RD = 1'b0;
        tick();
        check_val("stream_end", {31'b0, RVALID}, 32'h0);
        check_val("stream_hold", RDATA, 32'h3);

        // Reset in the middle of a debounce count and a read
        KEY = 2'b00;
        ticks(8);
        read(2'd2);
        KEY = 2'b01;
        ticks(5);
        RD   = 1'b1;
        ADDR = 2'd3;
        RST  = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("rst_mid");
        repeat (2) @(posedge CLK);
        #3;
        RST = 1'b1;
        RD  = 1'b0;
        tick();
        check_val("rst_mid_rvalid", {31'b0, RVALID}, 32'h0);
        ticks(4);
        check_val("rst_mid_irq_early", {31'b0, IRQ}, 32'h0);
        tick();
        check_val("rst_mid_irq_edge", {31'b0, IRQ}, 32'h1);

        // Random traffic with sticky key levels and occasional glitches
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) KEY[0] = ~KEY[0];
            if ($urandom_range(0, 5) == 0) KEY[1] = ~KEY[1];
            if ($urandom_range(0, 3) == 0) SW = SW_W'($urandom);
            if ($urandom_range(0, 3) == 0) GPIO = $urandom;
            RD   = ($urandom_range(0, 1) == 1);
            ADDR = 2'($urandom_range(0, 3));
            tick();
        end
        RD = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_input_reader.md
IO_INPUT_READER -- requirements
Module: io_input_reader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized cycles before a debounced key changes; legal range 1..255.
REQ-002 SHALL have parameter SW_W, default 10, switch input width.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port KEY  input  2  raw push-buttons, asynchronous, 1 = pressed.
REQ-006 SHALL have port SW  input  SW_W  raw slide switches, asynchronous.
REQ-007 SHALL have port GPIO  input  32  raw general-purpose inputs, asynchronous.
REQ-008 SHALL have port RD  input  1  read request, sampled each rising edge.
REQ-009 SHALL have port ADDR  input  2  register select, sampled with RD.
REQ-010 SHALL have port RDATA  output  32  read data, registered.
REQ-011 SHALL have port RVALID  output  1  one-cycle pulse marking RDATA valid.
REQ-012 SHALL have port IRQ  output  1  high while any key event flag is set.

Function
REQ-013 SHALL pass KEY, SW, GPIO each through a 2-flop synchronizer; synchronized value lags raw input by 2 cycles.
REQ-014 SHALL keep per key a debounced state and 8-bit counter; counter resets to 0 whenever synchronized bit equals debounced state.
REQ-015 SHALL increment the counter each cycle synchronized bit differs from debounced state; on the cycle it would reach DEBOUNCE_CYCLES, debounced state toggles and counter returns to 0.
REQ-016 SHALL, for a glitch shorter than DEBOUNCE_CYCLES synchronized cycles, leave debounced state unchanged.
REQ-017 SHALL set sticky event flag[i] on the cycle debounced key i goes 0->1; release (1->0) sets nothing.
REQ-018 SHALL register map: ADDR 0 = zero-extended synchronized SW; 1 = synchronized GPIO; 2 = {30'b0, event flags}; 3 = {30'b0, debounced keys}.
REQ-019 SHALL, when RD=1 at edge N, drive RDATA with the addressed value as of edge N and RVALID=1 after edge N; RVALID=0 after any edge with RD=0.
REQ-020 SHALL accept back-to-back reads: RD held high yields one RVALID per cycle, no stall.
REQ-021 SHALL hold RDATA at its last value while RVALID=0.
REQ-022 SHALL clear event flags on a read of ADDR 2 (clear-on-read), in the same edge that captures them into RDATA.
REQ-023 SHALL, when a new press sets flag[i] on the same edge as an ADDR 2 read, return the pre-edge flag value and leave flag[i]=1 (set wins over clear).
REQ-024 SHALL not alter flags on reads of ADDR 0, 1, 3.
REQ-025 SHALL drive IRQ registered as OR of event flags, i.e. IRQ reflects flags after the same edge.

Reset
REQ-026 SHALL, while RST=0, immediately force synchronizers, debounced states, counters, event flags, RDATA, RVALID, IRQ to 0.
REQ-027 SHALL, on RST asserted mid-debounce or mid-read, discard the pending count and read; no RVALID after deassertion unless RD is sampled again.
REQ-028 SHALL resume normal operation at the first rising edge after RST returns to 1.

Verification
REQ-029 SHALL verify reset: RST=0 with KEY=2'b11, SW=10'h3FF -> RDATA=0, RVALID=0, IRQ=0; after release and 2 cycles, read ADDR 0 -> RDATA=32'h000003FF.
REQ-030 SHALL verify debounce: KEY[0]=1 for 3 synchronized cycles then 0 -> ADDR 3 reads 0, IRQ=0; KEY[0]=1 held 10 cycles -> ADDR 3 reads 1, IRQ=1, first change exactly 2+4 cycles after KEY edge.
REQ-031 SHALL verify clear-on-read: after KEY[1] press, read ADDR 2 -> RDATA=32'h2, next read ADDR 2 -> RDATA=0, IRQ falls after first read edge.
REQ-032 SHALL verify simultaneous set/clear: flag[0]=1, KEY[1] press completes on same edge as ADDR 2 read -> RDATA=32'h1, flags afterward = 2'b10, IRQ stays 1.
REQ-033 SHALL verify streaming reads: GPIO=32'hDEADBEEF, RD=1 with ADDR 1,0,3 on consecutive edges -> RVALID high 3 cycles, RDATA=32'hDEADBEEF, zero-extended SW, debounced keys in order.
REQ-034 SHALL verify reset mid-operation: RST pulsed low during KEY debounce count 3 with RD=1 -> after release, RVALID=0, debounce restarts from 0 (full 4 cycles needed).
